// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read program memory port between
// the fetch (F) and decoder (D) requesters; bursts of 1-3 bytes are served atomically.
module mem_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [LEN_W-1:0]  f_len,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LEN_W-1:0]  d_len,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } req_t;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t            state;
  logic              owner, last_served;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  cnt;
  logic              rd_q, rd_own_q;

  logic              pick_d;
  req_t              sel;
  logic [LEN_W-1:0]  eff_len;

  // D wins when it is alone, or on a tie when F was served last.
  assign pick_d  = d_req & (~f_req | (last_served == OWN_F));
  assign sel     = pick_d ? '{addr: d_addr, len: d_len} : '{addr: f_addr, len: f_len};
  assign eff_len = (sel.len == '0) ? LEN_W'(1) : sel.len;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_D;
      last_served <= OWN_D;
      cur_addr    <= '0;
      cnt         <= '0;
      rd_q        <= 1'b0;
      rd_own_q    <= OWN_D;
      f_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      f_valid     <= 1'b0;
      d_valid     <= 1'b0;
      f_data      <= '0;
      d_data      <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
    end else begin
      f_gnt <= 1'b0;
      d_gnt <= 1'b0;

      // Read-return pipe: mem_data is live the cycle after mem_rd, then registered out.
      rd_q     <= mem_rd;
      rd_own_q <= owner;
      f_valid  <= rd_q & (rd_own_q == OWN_F);
      d_valid  <= rd_q & (rd_own_q == OWN_D);
      f_data   <= (rd_q && rd_own_q == OWN_F) ? mem_data : '0;
      d_data   <= (rd_q && rd_own_q == OWN_D) ? mem_data : '0;

      case (state)
        IDLE: if (f_req || d_req) begin
          owner       <= pick_d;
          last_served <= pick_d;
          f_gnt       <= ~pick_d;
          d_gnt       <= pick_d;
          mem_rd      <= 1'b1;
          mem_addr    <= sel.addr;
          cur_addr    <= sel.addr + 1'b1;
          cnt         <= eff_len;
          state       <= ISSUE;
        end
        ISSUE: begin
          // cnt counts issue cycles remaining, including the one on the port now.
          if (cnt == LEN_W'(1)) begin
            mem_rd <= 1'b0;
            state  <= DRAIN;
          end else begin
            mem_addr <= cur_addr;
            cur_addr <= cur_addr + 1'b1;
            cnt      <= cnt - 1'b1;
          end
        end
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory model, event monitor and
// hand-computed expected address/data/order sequences.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       f_req, d_req;
  logic [8:0] f_addr, d_addr;
  logic [1:0] f_len, d_len;
  logic       f_gnt, d_gnt, f_valid, d_valid, mem_rd, busy;
  logic [7:0] f_data, d_data, mem_data;
  logic [8:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(8), .LEN_W(2)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_len(f_len), .f_gnt(f_gnt),
    .f_valid(f_valid), .f_data(f_data),
    .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_data(d_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory contents: mem[a] = (a*7 + 3) mod 256, except mem[0x010] = 0x18.
  logic [7:0] mem [512];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'((i * 7 + 3) & 255);
    mem[9'h010] = 8'h18;
  end
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  int addr_q[$], fv_q[$], dv_q[$], ord_q[$], gnt_q[$], gcyc_q[$], vcyc_q[$];
  int stray = 0;

  always @(negedge clk) if (!reset) begin
    if (mem_rd)  addr_q.push_back(int'(mem_addr));
    if (f_valid) begin fv_q.push_back(int'(f_data)); ord_q.push_back(0); vcyc_q.push_back(cyc); end
    if (d_valid) begin dv_q.push_back(int'(d_data)); ord_q.push_back(1); vcyc_q.push_back(cyc); end
    if (f_gnt)   begin gnt_q.push_back(0); gcyc_q.push_back(cyc); end
    if (d_gnt)   begin gnt_q.push_back(1); gcyc_q.push_back(cyc); end
    if ((!f_valid && f_data != 0) || (!d_valid && d_data != 0) || (f_valid && d_valid)) stray++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int obs[$], input int exp[$]);
    chk({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < obs.size()) ? obs[i] : -1, exp[i]);
  endtask

  task automatic clear_q();
    addr_q.delete(); fv_q.delete(); dv_q.delete(); ord_q.delete();
    gnt_q.delete(); gcyc_q.delete(); vcyc_q.delete();
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk("busy_falls", int'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  // Raise the requested ports, drop each on its grant and scramble its
  // addr/len so only the latched values can be used.
  task automatic serve(input bit fr, input logic [8:0] fa, input logic [1:0] fl,
                       input bit dr, input logic [8:0] da, input logic [1:0] dl);
    f_addr = fa; f_len = fl; d_addr = da; d_len = dl; f_req = fr; d_req = dr;
    for (int n = 0; n < 40 && (f_req || d_req); n++) begin
      @(negedge clk);
      if (f_gnt) begin f_req = 0; f_addr = 9'h1AA; f_len = 2'd3; end
      if (d_gnt) begin d_req = 0; d_addr = 9'h155; d_len = 2'd3; end
    end
    chk("req_granted", int'({f_req, d_req}), 0);
    wait_quiet();
  endtask

  function automatic int outs_or();
    return int'(f_gnt | d_gnt | f_valid | d_valid | mem_rd | busy) |
           int'(f_data | d_data) | int'(mem_addr);
  endfunction

  int e[$];
  int n, fg;

  initial begin
    reset = 1; f_req = 0; d_req = 0; f_addr = 0; d_addr = 0; f_len = 0; d_len = 0;
    #3 chk("reset_outputs", outs_or(), 0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);

    // Single fetch
    clear_q();
    serve(1, 9'h010, 2'd1, 0, 9'h0, 2'd0);
    e = '{'h010}; chk_q("t1_addr", addr_q, e);
    e = '{'h18};  chk_q("t1_fdata", fv_q, e);
    chk("t1_dvalid_count", dv_q.size(), 0);
    e = '{0};     chk_q("t1_gnt", gnt_q, e);
    chk("t1_latency", (vcyc_q.size() > 0 && gcyc_q.size() > 0) ? vcyc_q[0] - gcyc_q[0] : -1, 2);

    // Tie after reset (last_served=D before this since t1 served F? no: F served, so D wins)
    // Use a fresh reset so the first tie goes to F.
    reset = 1; @(negedge clk); reset = 0; @(negedge clk);
    clear_q();
    serve(1, 9'h040, 2'd2, 1, 9'h080, 2'd2);
    e = '{'h040, 'h041, 'h080, 'h081}; chk_q("t2_addr", addr_q, e);
    e = '{0, 0, 1, 1};                 chk_q("t2_order", ord_q, e);
    e = '{'hC3, 'hCA};                 chk_q("t2_fdata", fv_q, e);
    e = '{'h83, 'h8A};                 chk_q("t2_ddata", dv_q, e);
    clear_q();
    serve(1, 9'h010, 2'd1, 1, 9'h011, 2'd1);
    e = '{0, 1};  chk_q("t2b_gnt", gnt_q, e);
    e = '{'h18};  chk_q("t2b_fdata", fv_q, e);
    e = '{'h7A};  chk_q("t2b_ddata", dv_q, e);

    // Wrap burst on D
    clear_q();
    serve(0, 9'h0, 2'd0, 1, 9'h1FF, 2'd3);
    e = '{'h1FF, 'h000, 'h001}; chk_q("t3_addr", addr_q, e);
    e = '{'hFC, 'h03, 'h0A};    chk_q("t3_ddata", dv_q, e);
    chk("t3_fvalid_count", fv_q.size(), 0);

    // Continuous F with D raised mid-burst
    clear_q();
    f_addr = 9'h100; f_len = 2'd3; f_req = 1;
    n = 0;
    while (!f_gnt && n < 20) begin @(negedge clk); n++; end
    chk("t4_first_gnt", int'(f_gnt), 1);
    d_addr = 9'h0C0; d_len = 2'd1; d_req = 1;
    fg = 1;
    for (int k = 0; k < 40 && (f_req || d_req); k++) begin
      @(negedge clk);
      if (d_gnt) d_req = 0;
      if (f_gnt) begin fg++; if (fg >= 2) f_req = 0; end
    end
    chk("t4_req_granted", int'({f_req, d_req}), 0);
    wait_quiet();
    e = '{0, 1, 0};                      chk_q("t4_gnt", gnt_q, e);
    e = '{0, 0, 0, 1, 0, 0, 0};          chk_q("t4_order", ord_q, e);
    e = '{'h100, 'h101, 'h102, 'h0C0, 'h100, 'h101, 'h102}; chk_q("t4_addr", addr_q, e);
    e = '{'h43};                         chk_q("t4_ddata", dv_q, e);
    chk("t4_gap_fd", (gcyc_q.size() > 1) ? gcyc_q[1] - gcyc_q[0] : -1, 5);
    chk("t4_gap_df", (gcyc_q.size() > 2) ? gcyc_q[2] - gcyc_q[1] : -1, 3);

    // Reset mid-burst, D served last so reset must restore last_served=D
    serve(0, 9'h0, 2'd0, 1, 9'h070, 2'd1);
    f_addr = 9'h030; f_len = 2'd3; f_req = 1;
    n = 0;
    while (!f_gnt && n < 20) begin @(negedge clk); n++; end
    chk("t5_gnt", int'(f_gnt), 1);
    f_req = 0;
    @(posedge clk); #1 reset = 1;
    #1 chk("t5_reset_outputs", outs_or(), 0);
    clear_q();
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("t5_no_valid_after_reset", fv_q.size() + dv_q.size(), 0);
    chk("t5_no_rd_after_reset", addr_q.size(), 0);
    serve(1, 9'h050, 2'd1, 1, 9'h060, 2'd1);
    e = '{0, 1};   chk_q("t5_tie_gnt", gnt_q, e);
    e = '{'h33};   chk_q("t5_fdata", fv_q, e);
    e = '{'hA3};   chk_q("t5_ddata", dv_q, e);

    // len=0 behaves as len=1
    clear_q();
    serve(1, 9'h020, 2'd0, 0, 9'h0, 2'd0);
    e = '{'h020}; chk_q("t6_addr", addr_q, e);
    e = '{'hE3};  chk_q("t6_fdata", fv_q, e);
    chk("t6_busy", int'(busy), 0);

    chk("stray_data_or_overlap", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
